// File: rtl/pma_pkg.sv
// Shared types and helpers for the runtime-programmable PMA table.
//   pma_attr_t  : attribute set returned by a lookup (lock bit is kept separately)
//   pma_field_e : table field selected by a configuration write
//   pma_hit()   : range match rule, evaluated one bit wider than the address
package pma_pkg;

  localparam int unsigned PmaMaxRegions   = 32;
  localparam int unsigned PmaMaxAddrWidth = 64;
  localparam int unsigned PmaIdxWidth     = $clog2(PmaMaxRegions);

  typedef struct packed {
    logic spm;
    logic nonidem;
    logic exec;
    logic cache;
  } pma_attr_t;

  typedef enum logic [1:0] {
    PmaFieldBase = 2'd0,
    PmaFieldLen  = 2'd1,
    PmaFieldAttr = 2'd2
  } pma_field_e;

  // Callers zero-extend to 64 bits; the 65-bit limit means base + len never wraps.
  function automatic logic pma_hit(input logic [PmaMaxAddrWidth-1:0] base,
                                   input logic [PmaMaxAddrWidth-1:0] len,
                                   input logic [PmaMaxAddrWidth-1:0] addr);
    logic [PmaMaxAddrWidth:0] limit;
    limit = {1'b0, base} + {1'b0, len};
    return (len != '0) && (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/cva6_pma_range_cmp.sv
// Combinational range check for one PMA table entry.
//   base_i, len_i : entry range [base, base + len); len == 0 disables the entry
//   addr_i        : lookup address
//   match_o       : address falls inside the entry range
module cva6_pma_range_cmp
  import pma_pkg::*;
#(
  parameter int unsigned AddrWidth = 56
) (
  input  logic [AddrWidth-1:0] base_i,
  input  logic [AddrWidth-1:0] len_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 match_o
);

  assign match_o = pma_hit(PmaMaxAddrWidth'(base_i), PmaMaxAddrWidth'(len_i),
                           PmaMaxAddrWidth'(addr_i));

endmodule

// File: rtl/cva6_pma_table.sv
// Runtime-programmable physical memory attribute table with a two-stage lookup pipeline.
//   cfg_*  : register-style write port (base / len / attr+lock per entry), cfg_err_o pulses
//            one cycle after a rejected write (locked entry or index out of range)
//   req_*  : lookup request (valid/ready), address captured into S1
//   rsp_*  : lookup response (valid/ready) from S2; lowest matching index wins
module cva6_pma_table
  import pma_pkg::*;
#(
  parameter int unsigned                          NrRegions   = 16,
  parameter int unsigned                          AddrWidth   = 56,
  parameter logic [NrRegions-1:0][AddrWidth-1:0] RstBase     = '0,
  parameter logic [NrRegions-1:0][AddrWidth-1:0] RstLen      = '0,
  parameter pma_attr_t [NrRegions-1:0]           RstAttr     = '0,
  parameter pma_attr_t                            DefaultAttr = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_we_i,
  input  logic [PmaIdxWidth-1:0] cfg_idx_i,
  input  logic [1:0]             cfg_field_i,
  input  logic [AddrWidth-1:0]   cfg_wdata_i,
  output logic                   cfg_err_o,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_hit_o,
  output logic [PmaIdxWidth-1:0] rsp_idx_o,
  output pma_attr_t              rsp_attr_o
);

  // Table state
  logic [AddrWidth-1:0] base_q [NrRegions];
  logic [AddrWidth-1:0] base_d [NrRegions];
  logic [AddrWidth-1:0] len_q  [NrRegions];
  logic [AddrWidth-1:0] len_d  [NrRegions];
  pma_attr_t            attr_q [NrRegions];
  pma_attr_t            attr_d [NrRegions];
  logic [NrRegions-1:0] lock_q, lock_d;
  logic                 cfg_err_q, cfg_err_d;

  // Pipeline state
  logic                   s1_valid_q, s1_valid_d;
  logic [AddrWidth-1:0]   s1_addr_q, s1_addr_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_hit_q, rsp_hit_d;
  logic [PmaIdxWidth-1:0] rsp_idx_q, rsp_idx_d;
  pma_attr_t              rsp_attr_q, rsp_attr_d;

  logic [NrRegions-1:0]   match;
  logic                   lk_hit;
  logic [PmaIdxWidth-1:0] lk_idx;
  pma_attr_t              lk_attr;
  logic                   s2_adv;
  logic                   idx_valid, idx_locked;

  for (genvar k = 0; k < NrRegions; k++) begin : g_cmp
    cva6_pma_range_cmp #(
      .AddrWidth (AddrWidth)
    ) u_cmp (
      .base_i  (base_q[k]),
      .len_i   (len_q[k]),
      .addr_i  (s1_addr_q),
      .match_o (match[k])
    );
  end

  // Priority encoder: walk downwards so the lowest matching index is written last.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_attr = DefaultAttr;
    for (int k = NrRegions - 1; k >= 0; k--) begin
      if (match[k]) begin
        lk_hit  = 1'b1;
        lk_idx  = PmaIdxWidth'(k);
        lk_attr = attr_q[k];
      end
    end
  end

  // Configuration writes
  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    attr_d     = attr_q;
    lock_d     = lock_q;
    cfg_err_d  = 1'b0;
    idx_valid  = 1'b0;
    idx_locked = 1'b0;
    for (int k = 0; k < NrRegions; k++) begin
      if (cfg_idx_i == PmaIdxWidth'(k)) begin
        idx_valid  = 1'b1;
        idx_locked = lock_q[k];
      end
    end
    if (cfg_we_i) begin
      if (!idx_valid || idx_locked) begin
        cfg_err_d = 1'b1;
      end else begin
        for (int k = 0; k < NrRegions; k++) begin
          if (cfg_idx_i == PmaIdxWidth'(k)) begin
            case (cfg_field_i)
              PmaFieldBase: base_d[k] = cfg_wdata_i;
              PmaFieldLen:  len_d[k]  = cfg_wdata_i;
              PmaFieldAttr: begin
                attr_d[k] = pma_attr_t'(cfg_wdata_i[3:0]);
                lock_d[k] = cfg_wdata_i[4];
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  // Lookup pipeline
  assign s2_adv      = !rsp_valid_q || rsp_ready_i;
  assign req_ready_o = !s1_valid_q || s2_adv;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_addr_d   = s1_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_attr_d  = rsp_attr_q;
    if (s2_adv) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_hit_d  = lk_hit;
        rsp_idx_d  = lk_idx;
        rsp_attr_d = lk_attr;
      end
    end
    if (req_ready_o) begin
      s1_valid_d = req_valid_i;
      if (req_valid_i) s1_addr_d = req_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NrRegions; k++) begin
        base_q[k] <= RstBase[k];
        len_q[k]  <= RstLen[k];
        attr_q[k] <= RstAttr[k];
      end
      lock_q      <= '0;
      cfg_err_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_attr_q  <= '0;
    end else begin
      base_q      <= base_d;
      len_q       <= len_d;
      attr_q      <= attr_d;
      lock_q      <= lock_d;
      cfg_err_q   <= cfg_err_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_attr_q  <= rsp_attr_d;
    end
  end

  assign cfg_err_o   = cfg_err_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign rsp_attr_o  = rsp_attr_q;

endmodule

// File: tb/tb_cva6_pma_table.sv
// Self-checking bench for cva6_pma_table: a reference table model produces expected
// lookup results that are queued at request handshake and checked at response handshake.
module tb_cva6_pma_table;
  import pma_pkg::*;

  localparam int unsigned NR = 16;
  localparam int unsigned AW = 56;

  typedef struct {
    logic       hit;
    logic [4:0] idx;
    logic [3:0] attr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [4:0]    cfg_idx;
  logic [1:0]    cfg_field;
  logic [AW-1:0] cfg_wdata;
  logic          cfg_err;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid, rsp_ready, rsp_hit;
  logic [4:0]    rsp_idx;
  logic [3:0]    rsp_attr;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  // Reference model
  logic [AW-1:0] m_base [NR];
  logic [AW-1:0] m_len  [NR];
  logic [3:0]    m_attr [NR];
  logic          m_lock [NR];
  localparam logic [3:0] DEF_ATTR = 4'b1010;

  cva6_pma_table #(
    .NrRegions   (NR),
    .AddrWidth   (AW),
    .RstBase     ((NR*AW)'(56'h8000_0000)),
    .RstLen      ((NR*AW)'(56'h1000_0000)),
    .RstAttr     ((NR*4)'(4'b0001)),
    .DefaultAttr (pma_attr_t'(4'b1010))
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_idx_i   (cfg_idx),
    .cfg_field_i (cfg_field),
    .cfg_wdata_i (cfg_wdata),
    .cfg_err_o   (cfg_err),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_hit_o   (rsp_hit),
    .rsp_idx_o   (rsp_idx),
    .rsp_attr_o  (rsp_attr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d)", n_tests);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int k = 0; k < NR; k++) begin
      m_base[k] = (k == 0) ? 56'h8000_0000 : '0;
      m_len[k]  = (k == 0) ? 56'h1000_0000 : '0;
      m_attr[k] = (k == 0) ? 4'b0001 : 4'b0000;
      m_lock[k] = 1'b0;
    end
  endfunction

  function automatic logic model_write(input int idx, input logic [1:0] f,
                                       input logic [AW-1:0] d);
    if (idx >= NR) return 1'b1;
    if (m_lock[idx]) return 1'b1;
    case (f)
      2'd0: m_base[idx] = d;
      2'd1: m_len[idx] = d;
      2'd2: begin
        m_attr[idx] = d[3:0];
        if (d[4]) m_lock[idx] = 1'b1;
      end
      default: ;
    endcase
    return 1'b0;
  endfunction

  function automatic exp_t model_lookup(input logic [AW-1:0] a);
    exp_t e;
    e.hit = 1'b0; e.idx = '0; e.attr = DEF_ATTR;
    for (int k = 0; k < NR; k++) begin
      if (m_len[k] != 0 && a >= m_base[k] &&
          ({1'b0, a} < ({1'b0, m_base[k]} + {1'b0, m_len[k]}))) begin
        e.hit = 1'b1; e.idx = 5'(k); e.attr = m_attr[k];
        break;
      end
    end
    return e;
  endfunction

  // Response monitor: pops one expectation per response handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got hit=%0b idx=%0d attr=%b, none expected",
                 rsp_hit, rsp_idx, rsp_attr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rsp_hit !== e.hit || rsp_idx !== e.idx || rsp_attr !== e.attr) begin
          n_fail++;
          $display("FAIL rsp_check: got hit=%0b idx=%0d attr=%b, want hit=%0b idx=%0d attr=%b",
                   rsp_hit, rsp_idx, rsp_attr, e.hit, e.idx, e.attr);
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input int idx, input logic [1:0] f, input logic [AW-1:0] d);
    logic exp_err;
    cfg_we = 1'b1; cfg_idx = 5'(idx); cfg_field = f; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    exp_err = model_write(idx, f, d);
    n_tests++;
    if (cfg_err !== exp_err) begin
      n_fail++;
      $display("FAIL cfg_err idx=%0d field=%0d: got %0b, want %0b", idx, f, cfg_err, exp_err);
    end
    if (exp_err) begin
      @(posedge clk); #1;
      n_tests++;
      if (cfg_err !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_err_pulse idx=%0d: got %0b, want 0", idx, cfg_err);
      end
    end
  endtask

  // Leaves req_valid high so consecutive calls issue back-to-back.
  task automatic lookup(input logic [AW-1:0] a);
    logic rdy;
    int   n;
    n = 0;
    req_valid = 1'b1; req_addr = a;
    do begin
      @(negedge clk); rdy = req_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      n_tests++; n_fail++;
      $display("FAIL req_timeout addr=%h: got ready=0, want 1", a);
    end else begin
      exp_q.push_back(model_lookup(a));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    req_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 0; cfg_idx = 0; cfg_field = 0; cfg_wdata = 0;
    req_valid = 0; req_addr = 0; rsp_ready = 1'b1;
    model_reset();
    #12;
    n_tests++;
    if ({rsp_valid, rsp_hit, rsp_idx, rsp_attr, cfg_err, req_ready} !== 13'b0_0_00000_0000_0_1) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b h=%0b i=%0d a=%b e=%0b r=%0b, want 0 0 0 0000 0 1",
               rsp_valid, rsp_hit, rsp_idx, rsp_attr, cfg_err, req_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_lookup();
    lookup(56'h8000_0010);
    req_valid = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_t1: got rsp_valid=%0b, want 0", rsp_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_t2: got rsp_valid=%0b, want 1", rsp_valid);
    end
    wait_drain();
  endtask

  task automatic test_overlap();
    do_write(2, 2'd0, 56'h1000); do_write(2, 2'd1, 56'h100);  do_write(2, 2'd2, 56'h02);
    do_write(5, 2'd0, 56'h1000); do_write(5, 2'd1, 56'h1000); do_write(5, 2'd2, 56'h04);
    lookup(56'h1080); lookup(56'h1800); lookup(56'h1_0000);
    wait_drain();
  endtask

  task automatic test_boundary();
    do_write(6, 2'd0, 56'hFF_FFFF_F000); do_write(6, 2'd1, 56'h1000);
    do_write(6, 2'd2, 56'h08);
    do_write(7, 2'd0, 56'hFF_FFFF_FFFF_F000); do_write(7, 2'd1, 56'h1000);
    do_write(7, 2'd2, 56'h01);
    do_write(8, 2'd0, 56'h2000); do_write(8, 2'd1, 56'h10); do_write(8, 2'd2, 56'h03);
    do_write(9, 2'd0, 56'h3000); do_write(9, 2'd1, 56'h0);  do_write(9, 2'd2, 56'h0F);
    lookup(56'hFF_FFFF_FFFF); lookup(56'hFF_FFFF_FFFF_FFFF); lookup(56'hFF_FFFF_FFFF_EFFF);
    lookup(56'h2010); lookup(56'h200F); lookup(56'h3000);
    wait_drain();
  endtask

  task automatic test_lock();
    do_write(3, 2'd0, 56'h5000); do_write(3, 2'd1, 56'h100);
    do_write(3, 2'd2, 56'h11);   // cache + lock
    do_write(3, 2'd0, 56'h6000); // rejected
    do_write(3, 2'd2, 56'h02);   // rejected
    do_write(20, 2'd0, 56'h7000);
    lookup(56'h5000); lookup(56'h6000);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    time t0;
    t0 = $time;
    lookup(56'h1080); lookup(56'h8000_0000); lookup(56'h2010);
    lookup(56'h1FFF); lookup(56'h5000);      lookup(56'h0);
    n_tests++;
    if ($time - t0 != 60) begin
      n_fail++;
      $display("FAIL throughput: got %0t time units for 6 requests, want 60", $time - t0);
    end
    wait_drain();
  endtask

  task automatic test_random_backpressure();
    logic [AW-1:0] addrs [9];
    logic done;
    addrs = '{56'h8000_0010, 56'h1080, 56'h1800, 56'h1_0000, 56'h2010,
              56'h200F, 56'hFF_FFFF_F800, 56'h3000, 56'h5000};
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) lookup(addrs[$urandom_range(0, 8)]);
        req_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
        rsp_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_stall_rewrite();
    exp_t e_old, e_new;
    int acc;
    logic wr_err;
    acc = 0;
    e_old = model_lookup(56'h8000_0010);
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 56'h8000_0010;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        cfg_we = 1'b1; cfg_idx = 5'd0; cfg_field = 2'd2; cfg_wdata = 56'h02;
      end
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
      cfg_we = 1'b0;
    end
    req_valid = 1'b0;
    wr_err = model_write(0, 2'd2, 56'h02);
    e_new = model_lookup(56'h8000_0010);
    if (acc >= 1) exp_q.push_back(e_old);
    if (acc >= 2) exp_q.push_back(e_new);
    n_tests++;
    if (acc != 2 || wr_err) begin
      n_fail++;
      $display("FAIL stall_accept: got %0d accepted, want 2", acc);
    end
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_attr !== e_old.attr) begin
      n_fail++;
      $display("FAIL stall_hold: got v=%0b attr=%b, want v=1 attr=%b",
               rsp_valid, rsp_attr, e_old.attr);
    end
    rsp_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 56'h1080;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_reset: got v=%0b ready=%0b, want v=0 ready=1", rsp_valid, req_ready);
    end
    exp_q.delete();
    model_reset();
    rsp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    lookup(56'h8000_0010); lookup(56'h1080); lookup(56'h5000);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_first_lookup();
    test_overlap();
    test_boundary();
    test_lock();
    test_back_to_back();
    test_random_backpressure();
    test_stall_rewrite();
    test_reset_midflight();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cva6_pma_table.md
Name: cva6_pma_table

Overview:
- Runtime-programmable physical memory attribute (PMA) table with a pipelined lookup port.
- Replaces the elaboration-time rule lists (separate non-idempotent, execute, cached and SPM lists) with one generalised table. The table has NrRegions entries; each entry holds a base, a length, an attribute set and a lock bit.
- Sits between the MMU/PMP stage and the cache/LSU request path.
- Firmware programs the table through a register-style write port. Lookups return the attributes of the highest-priority matching region.

Parameters:
- NrRegions, 16, number of table entries (1..32).
- AddrWidth, 56, physical address width of base, length and lookup address.
- RstBase, '0, NrRegions x AddrWidth array of reset base values.
- RstLen, '0, NrRegions x AddrWidth array of reset length values.
- RstAttr, '0, NrRegions x pma_attr_t array of reset attributes.
- DefaultAttr, '0, attribute set returned when no region matches.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_we_i  in  1  table write strobe, single cycle
- cfg_idx_i  in  5  entry index
- cfg_field_i  in  2  field select, pma_field_e: BASE, LEN, ATTR
- cfg_wdata_i  in  AddrWidth  write data; for ATTR, bits [4:0] = {lock, spm, nonidem, exec, cache}
- cfg_err_o  out  1  one-cycle pulse: write rejected
- req_valid_i  in  1  lookup request valid
- req_ready_o  out  1  lookup request ready
- req_addr_i  in  AddrWidth  lookup address
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_hit_o  out  1  some region matched
- rsp_idx_o  out  5  index of the winning region (0 when no hit)
- rsp_attr_o  out  4  pma_attr_t without the lock bit

Behaviour:
- Reset (asynchronous, rst_ni low):
  - Table loads RstBase, RstLen and RstAttr; all lock bits clear.
  - Both pipeline stages are emptied.
  - rsp_valid_o=0, rsp_hit_o=0, rsp_idx_o=0, rsp_attr_o=0, cfg_err_o=0, req_ready_o=1.
- Match rule for entry k:
  - addr >= base and {1'b0,addr} < ({1'b0,base}+len), computed at AddrWidth+1 bits so the sum cannot wrap.
  - len==0 disables the entry.
- Priority: the lowest matching index wins. No match gives hit=0, idx=0, attr=DefaultAttr.
- Pipeline, two stages (S1 = address register, S2 = result register):
  - Handshake at cycle T: the address is captured in S1.
  - During T+1 the S1 address is compared against the current table.
  - The result is registered into S2 when S2 is free or draining; rsp_valid_o is asserted at T+2.
  - Minimum latency is 2 cycles; throughput is 1 lookup per cycle.
- Handshake rules:
  - req_ready_o = !S1_valid or S1 advancing.
  - S2 advances when !rsp_valid_o or rsp_ready_i.
  - Outputs are held stable while rsp_valid_o && !rsp_ready_i.
- Stall: while S1 is blocked by S2 backpressure, the comparison is re-evaluated every cycle. The result reflects the table contents in the cycle S1 moves into S2.
- Write/lookup coherence:
  - A write accepted in cycle T is visible to any comparison in cycle T+1 onward.
  - A result already captured in S2 is never altered by a later write.
- Writes:
  - Accepted writes update only the selected field in the next cycle.
  - Writing ATTR with lock=1 sets the lock. The lock is sticky until reset.
  - A write to a locked entry (any field, including ATTR) or with cfg_idx_i >= NrRegions is dropped. cfg_err_o pulses high in the following cycle.
- Simultaneous events:
  - A write and a lookup in the same cycle are independent; the coherence rule above applies.
  - A request handshake and a response handshake in the same cycle with both stages full keeps full throughput and drops no request.
- Reset mid-operation: in-flight lookups are discarded with no response, and table programming is lost.

Decomposition:
- Package pma_pkg holds:
  - pma_attr_t, a packed struct {spm, nonidem, exec, cache}.
  - pma_field_e.
  - Constant PmaMaxRegions=32.
  - A function pma_hit(base,len,addr) implementing the 65-bit rule.
- Sub-module cva6_pma_range_cmp: one instance per entry, purely combinational, outputs the match bit.
- The top level holds the table registers, lock logic, priority encoder and the two pipeline stages.

Test Plan:
- Reset with RstBase[0]=0x8000_0000, RstLen[0]=0x1000_0000, RstAttr[0].cache=1; lookup 0x8000_0010 -> rsp at T+2, hit=1, idx=0, cache=1.
- Overlap: entry 2 = [0x1000, +0x100) exec; entry 5 = [0x1000, +0x1000) nonidem; lookup 0x1080 -> idx=2; lookup 0x1800 -> idx=5; lookup 0x1_0000 -> hit=0, attr=DefaultAttr.
- Boundary: base=0xFF_FFFF_F000, len=0x1000, AddrWidth=56; lookup 0xFF_FFFF_FFFF -> hit; entry with base=0x2000, len=0x10: lookup 0x2010 -> no hit; a len=0 entry never hits.
- Lock: write ATTR with lock=1 to entry 3, then write BASE to entry 3 -> cfg_err_o pulses for 1 cycle, base unchanged; write to idx 20 with NrRegions=16 -> cfg_err_o pulses.
- Backpressure: hold rsp_ready_i=0 for 5 cycles with 3 requests issued; rewrite entry 0 during the stall -> only 2 requests accepted; the S2 result is unchanged; the S1 result reflects the new entry; all responses arrive in order with none lost.
- Assert reset while both stages are valid -> rsp_valid_o=0 immediately; the table returns to its reset values; the first post-reset lookup sees reset contents.
